// File: rtl/capture_buffer.sv
// capture_buffer: circular pre-trigger ADC capture that streams a frozen record as bytes over valid/ready.
// Optional 4-byte record header is enabled by defining CAPTURE_HEADER_EN.
module capture_buffer #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned PRE_SAMPLES  = 64,
    parameter int unsigned POST_SAMPLES = 192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] ADC_IN,
    input  logic        trigger,
    input  logic        enable,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        capture_done,
    output logic [7:0]  trig_missed
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned N_SAMP = PRE_SAMPLES + POST_SAMPLES;
`ifdef CAPTURE_HEADER_EN
    localparam int unsigned HDR_BYTES = 4;
    localparam logic [15:0] N16       = 16'(N_SAMP);
`else
    localparam int unsigned HDR_BYTES = 0;
`endif
    localparam int unsigned TOTAL_BYTES = HDR_BYTES + 2 * N_SAMP;
    localparam int unsigned CNT_W       = ADDR_W + 1;
    localparam int unsigned BCNT_W      = ADDR_W + 3;

    typedef enum logic [1:0] {S_FILL, S_ARMED, S_POST, S_READOUT} state_t;

    state_t            r_state, w_state_nxt;
    logic [13:0]       r_mem [DEPTH];
    logic [13:0]       r_q;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [BCNT_W-1:0] r_byte_cnt;
    logic [7:0]        r_lo;
    logic              r_rd_wait;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_missed;

    logic       w_wr_en, w_cnt_inc, w_cnt_clr, w_trig_acc, w_missed;
    logic       w_load, w_hi_load, w_xfer, w_done, w_enter_rd;
    logic [7:0] w_byte_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FILL;
        else        r_state <= w_state_nxt;
    end

    // Next state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_trig_acc  = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_xfer      = r_tx_valid && tx_ready;
        case (r_state)
            S_FILL: begin
                w_wr_en   = 1'b1;
                w_cnt_inc = 1'b1;
                if (r_cnt == CNT_W'(PRE_SAMPLES - 1)) begin
                    w_state_nxt = S_ARMED;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_ARMED: begin
                w_wr_en = 1'b1;
                if (trigger && enable) begin
                    w_trig_acc  = 1'b1;
                    w_state_nxt = (POST_SAMPLES == 1) ? S_READOUT : S_POST;
                end
            end
            S_POST: begin
                w_wr_en   = 1'b1;
                w_cnt_inc = 1'b1;
                if (r_cnt == CNT_W'(POST_SAMPLES - 1)) begin
                    w_state_nxt = S_READOUT;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_READOUT: begin
                w_load = (!r_tx_valid || tx_ready) && !r_rd_wait
                         && (r_byte_cnt != BCNT_W'(TOTAL_BYTES));
                if (w_xfer && (r_byte_cnt == BCNT_W'(TOTAL_BYTES))) begin
                    w_done      = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
        w_missed   = trigger && !w_trig_acc;
        w_enter_rd = (w_state_nxt == S_READOUT) && (r_state != S_READOUT);
    end

    // Byte selection: header constants, then high byte from RAM, then the saved low byte.
    always_comb begin
        w_byte_nxt = r_byte_cnt[0] ? r_lo : {2'b00, r_q[13:8]};
        w_hi_load  = w_load && !r_byte_cnt[0];
`ifdef CAPTURE_HEADER_EN
        if (r_byte_cnt < BCNT_W'(HDR_BYTES)) begin
            w_hi_load = 1'b0;
            case (r_byte_cnt[1:0])
                2'd0:    w_byte_nxt = 8'hA5;
                2'd1:    w_byte_nxt = 8'h5A;
                2'd2:    w_byte_nxt = N16[15:8];
                default: w_byte_nxt = N16[7:0];
            endcase
        end
`endif
    end

    // Sample memory: no writes in READOUT, so the read port sees a frozen record.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= ADC_IN;
        r_q <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_lo       <= '0;
            r_rd_wait  <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_missed   <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);

            if (w_cnt_clr)       r_cnt <= '0;
            else if (w_trig_acc) r_cnt <= CNT_W'(1);
            else if (w_cnt_inc)  r_cnt <= r_cnt + CNT_W'(1);

            // Read pointer doubles as the latched record start.
            if (w_trig_acc) begin
                r_rd_ptr   <= r_wr_ptr - ADDR_W'(PRE_SAMPLES);
                r_byte_cnt <= '0;
            end else if (w_hi_load) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end

            if (w_hi_load) r_lo <= r_q[7:0];
            r_rd_wait <= w_enter_rd;

            if (w_load) begin
                r_tx_data  <= w_byte_nxt;
                r_tx_valid <= 1'b1;
                r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            end else if (w_xfer) begin
                r_tx_valid <= 1'b0;
            end

            r_busy <= (w_state_nxt == S_POST) || (w_state_nxt == S_READOUT);
            r_done <= w_done;
            if (w_missed && (r_missed != 8'hFF)) r_missed <= r_missed + 8'd1;
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign busy         = r_busy;
    assign capture_done = r_done;
    assign trig_missed  = r_missed;

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: expected bytes are queued by stimulus, popped by a monitor on each transfer.
module tb_capture_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [13:0] ADC_IN = '0;
    logic        trigger = 1'b0;
    logic        enable = 1'b1;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        capture_done;
    logic [7:0]  trig_missed;

    always #5 clk = ~clk;

    capture_buffer #(.ADDR_W(3), .PRE_SAMPLES(3), .POST_SAMPLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ADC_IN(ADC_IN), .trigger(trigger), .enable(enable),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .capture_done(capture_done), .trig_missed(trig_missed)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         byte_cnt = 0;
    int         cyc = 0;
    logic       rnd_ready = 1'b0;
    logic       hold_pend = 1'b0;
    logic [7:0] held = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, i.e. the state that the next rising edge acts on.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("tx_valid_held", int'(tx_valid), 1);
                check("tx_data_stable", int'(tx_data), int'(held));
            end
            hold_pend = tx_valid && !tx_ready;
            held      = tx_data;
            if (tx_valid && tx_ready) begin
                byte_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte: got %0d expected no byte", tx_data);
                end else begin
                    check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
                end
            end
            if (capture_done) done_cnt++;
        end
    end

    // Ready driver: held high, or pseudo-random while backpressure is enabled.
    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ADC_IN = 14'(cyc);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        trigger = 1'b0;
        exp_q.delete();
        #1;
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_capture_done", int'(capture_done), 0);
        check("rst_trig_missed", int'(trig_missed), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cyc    = 0;
        ADC_IN = '0;
    endtask

    task automatic push_record(input int first);
`ifdef CAPTURE_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h07);
`endif
        for (int i = 0; i < 7; i++) begin
            logic [13:0] s;
            s = 14'(first + i);
            exp_q.push_back({2'b00, s[13:8]});
            exp_q.push_back(s[7:0]);
        end
    endtask

    // Pulse trigger at cycle trig_at; optionally re-pulse extra_at cycles later; wait for the record end.
    task automatic run_record(input int trig_at, input int extra_at, input int budget);
        int d0;
        int k;
        push_record(trig_at - 3);
        while (cyc < trig_at) step();
        d0 = done_cnt;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("busy_after_trigger", int'(busy), 1);
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            trigger = (extra_at > 0 && k == extra_at);
            step();
            k++;
        end
        trigger = 1'b0;
        check("record_done_in_budget", int'(done_cnt > d0), 1);
        check("busy_at_done", int'(busy), 0);
        repeat (3) step();
        check("capture_done_pulses", done_cnt - d0, 1);
        check("bytes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        int b0;
        int k;
        #2;
        do_reset();

        // Basic record, then an automatic re-arm without reset.
        run_record(10, 0, 200);
        check("missed_basic", int'(trig_missed), 0);
        run_record(cyc + 5, 0, 200);
        check("missed_rearm", int'(trig_missed), 0);

        // Trigger during FILL is missed.
        do_reset();
        step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("missed_in_fill", int'(trig_missed), 1);
        repeat (4) step();
        check("no_record_from_fill", int'(busy), 0);
        run_record(10, 0, 200);
        check("missed_after_fill_case", int'(trig_missed), 1);

        // Backpressure.
        do_reset();
        rnd_ready = 1'b1;
        run_record(10, 0, 600);
        rnd_ready = 1'b0;

        // Wrap-around plus a trigger during READOUT.
        do_reset();
        run_record(20, 8, 200);
        check("missed_in_readout", int'(trig_missed), 1);

        // Reset mid-readout, then a fresh record.
        do_reset();
        push_record(7);
        while (cyc < 10) step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        b0 = byte_cnt;
        k = 0;
        while (byte_cnt - b0 < 5 && k < 200) begin
            step();
            k++;
        end
        check("reached_fifth_byte", int'(byte_cnt - b0 >= 5), 1);
        do_reset();
        run_record(10, 0, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
